// File: rtl/rtmq_edge_stamper.sv
// rtmq_edge_stamper: time-tags qualifying edges of an asynchronous input against the RTMQ
// wall clock and queues {polarity, 64-bit stamp} entries in a first-word-fall-through FIFO.
// Optional feature: define RTMQ_STAMP_LATCOMP_EN to subtract the synchronizer latency so the
// stamp names the sampling cycle instead of the detect cycle.
module rtmq_edge_stamper #(
    parameter int unsigned W_REG = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned N_SYN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [W_REG-1:0]         wck,
    input  logic [W_REG-1:0]         tim,
    input  logic                     din,
    input  logic                     cfg_en,
    input  logic [1:0]               cfg_edge,
    input  logic                     pop,
    input  logic                     clr,
    output logic [W_REG-1:0]         stamp_lo,
    output logic [W_REG-1:0]         stamp_hi,
    output logic                     stamp_pol,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     f_empty,
    output logic                     f_ovf
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned SW    = 2 * W_REG;
    localparam int unsigned WarmW = $clog2(N_SYN + 2);
    localparam logic [WarmW-1:0] WarmInit = WarmW'(N_SYN + 1);

    logic [N_SYN-1:0] sync_q;
    logic             hist_q;
    logic [WarmW-1:0] warm_q;
    logic [W_REG-1:0] wck_q;

    logic             sync_out;
    logic             edge_det;
    logic             edge_sel;
    logic             push_req;
    logic [W_REG-1:0] hi_eff;
    logic [SW-1:0]    stamp_wr;

    logic [SW:0]      mem_q [DEPTH];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [SW:0]      hold_q, head_out;
    logic             full, empty, do_push, do_pop, ovf_set;

    // Synchronizer chain, edge history, warm-up mask and wall-clock delay register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            warm_q <= WarmInit;
            wck_q  <= '0;
        end else begin
            sync_q <= {sync_q[N_SYN-2:0], din};
            hist_q <= sync_q[N_SYN-1];
            wck_q  <= wck;
            if (warm_q != '0) begin
                warm_q <= warm_q - WarmW'(1);
            end
        end
    end

    // Edge qualification and stamp formation in the detect cycle.
    always_comb begin
        sync_out = sync_q[N_SYN-1];
        edge_det = (sync_out != hist_q) && (warm_q == '0);
        edge_sel = sync_out ? cfg_edge[0] : cfg_edge[1];
        push_req = cfg_en && edge_det && edge_sel;
        // tim lags the wck wrap by one cycle; patch the upper word in that cycle only.
        hi_eff   = ((wck == '0) && (wck_q == '1)) ? tim + W_REG'(1) : tim;
`ifdef RTMQ_STAMP_LATCOMP_EN
        stamp_wr = {hi_eff, wck} - SW'(N_SYN);
`else
        stamp_wr = {hi_eff, wck};
`endif
    end

    // FIFO control: clear wins, push/pop arbitration, overflow detection.
    always_comb begin
        full    = (cnt_q == CntW'(DEPTH));
        empty   = (cnt_q == '0);
        do_pop  = pop && !empty && !clr;
        do_push = push_req && !clr && (!full || do_pop);
        ovf_set = push_req && !clr && full && !do_pop;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (do_push) wr_d = wr_q + PtrW'(1);
            if (do_pop)  rd_d = rd_q + PtrW'(1);
            if (do_push && !do_pop) cnt_d = cnt_q + CntW'(1);
            if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
            if (ovf_set) ovf_d = 1'b1;
        end
    end

    // FIFO pointer, count, overflow and output-hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            hold_q <= head_out;
        end
    end

    // Entry storage; contents are only observed while the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= {sync_out, stamp_wr};
        end
    end

    // Head is shown while non-empty; otherwise the last shown value is held.
    always_comb begin
        head_out  = empty ? hold_q : mem_q[rd_q];
        stamp_lo  = head_out[W_REG-1:0];
        stamp_hi  = head_out[SW-1:W_REG];
        stamp_pol = head_out[SW];
        fifo_cnt  = cnt_q;
        f_empty   = empty;
        f_ovf     = ovf_q;
    end

endmodule

// File: tb/tb_rtmq_edge_stamper.sv
// Self-checking bench for rtmq_edge_stamper: expected entries are queued when din is toggled
// and compared against the FIFO head as the bench pops them.
module tb_rtmq_edge_stamper;

    localparam int W_REG = 32;
    localparam int DEPTH = 16;
    localparam int N_SYN = 2;
`ifdef RTMQ_STAMP_LATCOMP_EN
    localparam int L = N_SYN;
`else
    localparam int L = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [W_REG-1:0]       wck, tim;
    logic                   din, cfg_en, pop, clr;
    logic [1:0]             cfg_edge;
    logic [W_REG-1:0]       stamp_lo, stamp_hi;
    logic                   stamp_pol, f_empty, f_ovf;
    logic [$clog2(DEPTH):0] fifo_cnt;

    typedef struct packed {
        logic [63:0] st;
        logic        pol;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] now64;
    int          n_cmp = 0;
    int          n_bad = 0;

    rtmq_edge_stamper #(
        .W_REG (W_REG),
        .DEPTH (DEPTH),
        .N_SYN (N_SYN)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wck       (wck),
        .tim       (tim),
        .din       (din),
        .cfg_en    (cfg_en),
        .cfg_edge  (cfg_edge),
        .pop       (pop),
        .clr       (clr),
        .stamp_lo  (stamp_lo),
        .stamp_hi  (stamp_hi),
        .stamp_pol (stamp_pol),
        .fifo_cnt  (fifo_cnt),
        .f_empty   (f_empty),
        .f_ovf     (f_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // Wall clock model: tim follows the upper word of the previous cycle's 64-bit time.
    task automatic set_time(input logic [63:0] t);
        logic [63:0] p;
        p     = t - 64'd1;
        now64 = t;
        wck   = t[31:0];
        tim   = p[63:32];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_time(now64 + 64'd1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // din changes in the current cycle, so T is the current wall-clock time.
    task automatic toggle(input bit expect_push);
        exp_t e;
        din = ~din;
        if (expect_push) begin
            e.st  = now64 + 64'(N_SYN) - 64'(L);
            e.pol = din;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_head(input string tag);
        check_eq({tag, ":empty"}, f_empty, 0);
        check_eq({tag, ":stamp"}, {stamp_hi, stamp_lo}, exp_q[0].st);
        check_eq({tag, ":pol"}, stamp_pol, exp_q[0].pol);
    endtask

    task automatic drain(input string tag);
        logic [63:0] last;
        bit          any;
        any  = 0;
        last = '0;
        while (exp_q.size() > 0) begin
            check_head(tag);
            check_eq({tag, ":cnt"}, fifo_cnt, exp_q.size());
            last = exp_q[0].st;
            any  = 1;
            void'(exp_q.pop_front());
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        check_eq({tag, ":done_empty"}, f_empty, 1);
        check_eq({tag, ":done_cnt"}, fifo_cnt, 0);
        if (any) check_eq({tag, ":hold"}, {stamp_hi, stamp_lo}, last);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ":lo"}, stamp_lo, 0);
        check_eq({tag, ":hi"}, stamp_hi, 0);
        check_eq({tag, ":pol"}, stamp_pol, 0);
        check_eq({tag, ":cnt"}, fifo_cnt, 0);
        check_eq({tag, ":empty"}, f_empty, 1);
        check_eq({tag, ":ovf"}, f_ovf, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        din      = 1'b0;
        cfg_en   = 1'b0;
        cfg_edge = 2'b00;
        pop      = 1'b0;
        clr      = 1'b0;
        set_time(64'd1);
        ticks(3);
        check_reset("rst");
        rst_n = 1'b1;
        ticks(6);
        check_eq("idle_empty", f_empty, 1);

        // Single rising edge at T=100, tim=0; head becomes valid three cycles after T.
        cfg_en   = 1'b1;
        cfg_edge = 2'b01;
        set_time(64'd100);
        toggle(1);
        ticks(2);
        check_eq("lat_early", f_empty, 1);
        tick();
        check_eq("lat_valid", f_empty, 0);
        drain("single");

        // Falling edge is not selected; then a rise straddling the wck wrap.
        toggle(0);
        ticks(4);
        check_eq("fall_ignored", f_empty, 1);
        set_time({32'd5, 32'hFFFF_FFFE});
        toggle(1);
        ticks(4);
        drain("wrap");

        // Fall-only select on a three-cycle pulse, then both edges.
        cfg_en = 1'b0;
        toggle(0);
        ticks(4);
        cfg_en   = 1'b1;
        cfg_edge = 2'b10;
        toggle(0);
        ticks(3);
        toggle(1);
        ticks(4);
        drain("fall_only");
        cfg_edge = 2'b11;
        toggle(1);
        ticks(3);
        toggle(1);
        ticks(4);
        check_eq("both:cnt", fifo_cnt, 2);
        drain("both");

        // Edges on consecutive cycles.
        toggle(1);
        tick();
        toggle(1);
        tick();
        toggle(1);
        ticks(4);
        drain("b2b");

        // Overflow: 17 edges, the last one dropped.
        for (int i = 0; i < 17; i++) begin
            toggle(i < DEPTH);
            tick();
        end
        ticks(4);
        check_eq("ovf:cnt", fifo_cnt, DEPTH);
        check_eq("ovf:flag", f_ovf, 1);
        check_head("ovf_head");
        // 18th edge written in the same cycle as a pop.
        toggle(1);
        ticks(2);
        check_head("ovf_head2");
        void'(exp_q.pop_front());
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check_eq("ovf_pp:cnt", fifo_cnt, DEPTH);
        check_eq("ovf_pp:flag", f_ovf, 1);
        drain("ovf_drain");

        // Clear together with a pop and a detected edge; overflow flag still set here.
        toggle(0);
        tick();
        toggle(0);
        ticks(2);
        check_eq("clr_pre:cnt", fifo_cnt, 1);
        pop = 1'b1;
        clr = 1'b1;
        tick();
        pop = 1'b0;
        clr = 1'b0;
        check_eq("clr:cnt", fifo_cnt, 0);
        check_eq("clr:empty", f_empty, 1);
        check_eq("clr:ovf", f_ovf, 0);
        ticks(4);
        check_eq("clr_late:empty", f_empty, 1);

        // Asynchronous reset with an entry held, then warm-up with din high.
        toggle(1);
        ticks(4);
        check_eq("pre_rst:empty", f_empty, 0);
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        exp_q.delete();
        din = 1'b1;
        ticks(3);
        rst_n = 1'b1;
        ticks(8);
        check_eq("warm:empty", f_empty, 1);
        check_eq("warm:cnt", fifo_cnt, 0);
        toggle(1);
        ticks(4);
        drain("warm_fall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
